// File: rtl/inverse_interpolator_1d_if.sv
// Request/result bundle for the inverse 1-D interpolator: target value,
// eight knot weights, and the one-shot result.
interface inverse_interpolator_1d_if;
  logic       i_valid;
  logic       o_ready;
  logic [9:0] i_y;
  logic [9:0] i_weight0;
  logic [9:0] i_weight1;
  logic [9:0] i_weight2;
  logic [9:0] i_weight3;
  logic [9:0] i_weight4;
  logic [9:0] i_weight5;
  logic [9:0] i_weight6;
  logic [9:0] i_weight7;
  logic       o_valid;
  logic [7:0] o_x;
  logic       o_sat;

  modport master (
    output i_valid, i_y,
    output i_weight0, i_weight1, i_weight2, i_weight3,
    output i_weight4, i_weight5, i_weight6, i_weight7,
    input  o_ready, o_valid, o_x, o_sat
  );

  modport slave (
    input  i_valid, i_y,
    input  i_weight0, i_weight1, i_weight2, i_weight3,
    input  i_weight4, i_weight5, i_weight6, i_weight7,
    output o_ready, o_valid, o_x, o_sat
  );
endinterface

// File: rtl/inverse_interpolator_1d.sv
// Inverse piecewise-linear interpolator: finds the smallest 8-bit x whose
// interpolated value reaches the target, by an 8-step sequential bisection.
module inverse_interpolator_1d (
  input  logic                         clk,
  input  logic                         rst_n,
  inverse_interpolator_1d_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_CHECK, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [9:0]      r_y;
  logic [7:0][9:0] r_w;
  logic [7:0]      r_lo;
  logic [7:0]      r_hi;
  logic [2:0]      r_cnt;
  logic [7:0]      r_x;
  logic            r_sat;

  logic            w_accept;
  logic [8:0]      w_sum;
  logic [7:0]      w_mid;
  logic [7:0]      w_eval_x;
  logic [9:0]      w_f;
  logic            w_ge;

  // Forward model; the arithmetic shift floors negative slopes.
  function automatic logic [9:0] fwd(input logic [7:0] x, input logic [7:0][9:0] w);
    logic [2:0]         k;
    logic [2:0]         kn;
    logic signed [15:0] diff;
    logic signed [15:0] frs;
    logic signed [15:0] prod;
    logic signed [15:0] sum;
    k    = x[7:5];
    kn   = k + 3'd1;
    diff = $signed({6'd0, w[kn]}) - $signed({6'd0, w[k]});
    frs  = $signed({11'd0, x[4:0]});
    prod = diff * frs;
    sum  = $signed({6'd0, w[k]}) + (prod >>> 5);
    if (k == 3'd7) fwd = w[7];
    else           fwd = 10'(sum);
  endfunction

  assign w_accept = bus.i_valid && (r_state == S_IDLE);
  assign w_sum    = {1'b0, r_lo} + {1'b0, r_hi};
  assign w_mid    = 8'(w_sum >> 1);
  // One evaluator serves both the bisection probe and the final reachability test.
  assign w_eval_x = (r_state == S_CHECK) ? r_lo : w_mid;
  assign w_f      = fwd(w_eval_x, r_w);
  assign w_ge     = (w_f >= r_y);

  assign bus.o_ready = (r_state == S_IDLE);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_x     = r_x;
  assign bus.o_sat   = r_sat;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SEARCH;
      S_SEARCH: if (r_cnt == 3'd7) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_w   <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_cnt <= '0;
      r_x   <= '0;
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_y   <= bus.i_y;
            r_w   <= {bus.i_weight7, bus.i_weight6, bus.i_weight5, bus.i_weight4,
                      bus.i_weight3, bus.i_weight2, bus.i_weight1, bus.i_weight0};
            r_lo  <= 8'd0;
            r_hi  <= 8'd255;
            r_cnt <= 3'd0;
          end
        end
        S_SEARCH: begin
          // Once the interval collapses the remaining steps leave it untouched.
          if (r_lo < r_hi) begin
            if (w_ge) r_hi <= w_mid;
            else      r_lo <= w_mid + 8'd1;
          end
          r_cnt <= r_cnt + 3'd1;
        end
        S_CHECK: begin
          r_sat <= !w_ge;
          r_x   <= w_ge ? r_lo : 8'd255;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_interpolator_1d.sv
// Directed bench for inverse_interpolator_1d: table of targets plus
// handshake, throughput and reset-abort sequences.
module tb_inverse_interpolator_1d;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inverse_interpolator_1d_if bus ();

  inverse_interpolator_1d dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    string           name;
    logic [9:0]      y;
    logic [7:0][9:0] w;
    bit              chg;
    logic [7:0]      x;
    logic            sat;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_w(input logic [7:0][9:0] w);
    bus.i_weight0 = w[0]; bus.i_weight1 = w[1];
    bus.i_weight2 = w[2]; bus.i_weight3 = w[3];
    bus.i_weight4 = w[4]; bus.i_weight5 = w[5];
    bus.i_weight6 = w[6]; bus.i_weight7 = w[7];
  endtask

  function automatic int ref_f(input int x, input logic [7:0][9:0] w);
    int k;
    int fr;
    k  = x / 32;
    fr = x % 32;
    if (k == 7) return int'(w[7]);
    return int'(w[k]) + (((int'(w[k+1]) - int'(w[k])) * fr) >>> 5);
  endfunction

  function automatic int ref_search(input int y, input logic [7:0][9:0] w);
    int lo;
    int hi;
    int mid;
    lo = 0;
    hi = 255;
    for (int i = 0; i < 8; i++) begin
      if (lo < hi) begin
        mid = (lo + hi) / 2;
        if (ref_f(mid, w) >= y) hi = mid;
        else lo = mid + 1;
      end
    end
    if (ref_f(lo, w) < y) return 255;
    return lo;
  endfunction

  // Handshake at edge T; negedge n follows edge T+n-1.
  task automatic do_req(input logic [9:0] y, input logic [7:0][9:0] w, input bit chg,
                        output logic [7:0] x, output logic sat, output int lat,
                        output int rlo, output logic [1:0] post);
    x = '0; sat = 1'b0; lat = -1; rlo = 0; post = 2'b00;
    @(negedge clk);
    bus.i_y = y;
    set_w(w);
    bus.i_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.i_valid = 1'b0;
        if (chg) begin
          bus.i_y = ~y;
          set_w(~w);
        end
      end
      if (!bus.o_ready) rlo++;
      if (bus.o_valid) begin
        lat = n;
        x = bus.o_x;
        sat = bus.o_sat;
        break;
      end
    end
    @(negedge clk);
    post = {bus.o_ready, bus.o_valid};
  endtask

  logic [7:0][9:0] ramp;
  logic [7:0][9:0] flat;
  logic [7:0]      rx;
  logic            rsat;
  int              lat;
  int              rlo;
  logic [1:0]      post;
  int              pulses;
  int              ppos[4];

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 8; k++) begin
      ramp[k] = 10'(100 * k);
      flat[k] = 10'd50;
    end
    flat[3] = 10'd300;
    flat[4] = 10'd300;
    flat[5] = 10'd200;

    tv[0] = '{"y0",      10'd0,    ramp, 1'b0, 8'd0,   1'b0};
    tv[1] = '{"y100",    10'd100,  ramp, 1'b0, 8'd32,  1'b0};
    tv[2] = '{"y150",    10'd150,  ramp, 1'b0, 8'd48,  1'b0};
    tv[3] = '{"y700",    10'd700,  ramp, 1'b0, 8'd224, 1'b0};
    tv[4] = '{"y701",    10'd701,  ramp, 1'b0, 8'd255, 1'b1};
    tv[5] = '{"y1023",   10'd1023, ramp, 1'b0, 8'd255, 1'b1};
    tv[6] = '{"flat300", 10'd300,  flat, 1'b0, 8'd96,  1'b0};
    tv[7] = '{"flat51",  10'd51,   flat, 1'b0, 8'(ref_search(51, flat)), 1'b0};
    tv[8] = '{"chg150",  10'd150,  ramp, 1'b1, 8'd48,  1'b0};

    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_y = '0;
    set_w(ramp);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 1);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_x",     32'(bus.o_x),     0);
    chk("rst_sat",   32'(bus.o_sat),   0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_req(tv[i].y, tv[i].w, tv[i].chg, rx, rsat, lat, rlo, post);
      chk({tv[i].name, "_x"},     32'(rx),   32'(tv[i].x));
      chk({tv[i].name, "_sat"},   32'(rsat), 32'(tv[i].sat));
      chk({tv[i].name, "_lat"},   32'(lat),  10);
      chk({tv[i].name, "_rlo"},   32'(rlo),  10);
      chk({tv[i].name, "_post"},  32'(post), 32'(2'b10));
    end

    // Extra i_valid pulse while busy must not produce a second result.
    @(negedge clk);
    bus.i_y = 10'd100;
    set_w(ramp);
    bus.i_valid = 1'b1;
    @(posedge clk);
    pulses = 0;
    lat = -1;
    rx = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_valid = 1'b0;
      if (n == 3) bus.i_valid = 1'b1;
      if (n == 4) bus.i_valid = 1'b0;
      if (bus.o_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          rx = bus.o_x;
        end
      end
    end
    chk("busy_pulses", 32'(pulses), 1);
    chk("busy_lat",    32'(lat),    10);
    chk("busy_x",      32'(rx),     32);

    // Held i_valid: results every 11 cycles.
    @(negedge clk);
    bus.i_y = 10'd150;
    set_w(ramp);
    bus.i_valid = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        if (pulses < 4) ppos[pulses] = n;
        pulses++;
        chk("b2b_x", 32'(bus.o_x), 48);
      end
      if (n == 44) bus.i_valid = 1'b0;
    end
    chk("b2b_count", 32'(pulses), 4);
    for (int p = 0; p < 4; p++)
      if (p < pulses) chk("b2b_pos", 32'(ppos[p]), 32'(10 + 11 * p));
    repeat (3) @(negedge clk);
    chk("b2b_idle_ready", 32'(bus.o_ready), 1);

    // Result register is nonzero before the abort so the reset is visible.
    do_req(10'd1023, ramp, 1'b0, rx, rsat, lat, rlo, post);
    chk("pre_rst_x", 32'(rx), 255);
    @(negedge clk);
    bus.i_y = 10'd300;
    bus.i_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.o_ready), 1);
    chk("abort_valid", 32'(bus.o_valid), 0);
    chk("abort_x",     32'(bus.o_x),     0);
    chk("abort_sat",   32'(bus.o_sat),   0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.o_valid) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 0);
    do_req(10'd150, ramp, 1'b0, rx, rsat, lat, rlo, post);
    chk("after_rst_x",   32'(rx),  48);
    chk("after_rst_lat", 32'(lat), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
